// File: rtl/vdec_hs_sched.sv
// vdec_hs_sched: job scheduler in front of the shared HS Viterbi decoder.
// Latches single-cycle start requests, launches one decode at a time by
// fixed priority (part1 > ns_part1 > agch > part2 > ns_part2) and returns
// a per-job done pulse.
// Optional decode watchdog: define VDEC_HS_SCHED_TIMEOUT_EN.
module vdec_hs_sched #(
    parameter int unsigned           TO_W   = 12,
    parameter logic [TO_W-1:0]       TO_MAX = TO_W'(3000)
) (
    input  logic       clk,
    input  logic       res,
    input  logic       start_part1,
    input  logic       start_part2,
    input  logic       start_ns_part1,
    input  logic       start_ns_part2,
    input  logic       start_agch,
    input  logic       dec_busy,
    input  logic       dec_done,
    output logic       dec_start,
    output logic [2:0] dec_job,
    output logic       done_hsscch_part1,
    output logic       done_hsscch_part2,
    output logic       done_ns_hsscch_part1,
    output logic       done_ns_hsscch_part2,
    output logic       done_agch,
    output logic       sched_busy,
    output logic [4:0] pend,
    output logic [4:0] ovf,
    input  logic       ovf_clr,
    output logic       tmo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_RUN,
        S_FIN
    } state_t;

    state_t     state_q;
    logic [4:0] pend_q, pend_d;
    logic [4:0] ovf_q, ovf_d;
    logic [4:0] start_vec;
    logic [4:0] grant;
    logic [2:0] grant_job;
    logic [2:0] job_q;
    logic       start_q;
    logic [4:0] done_q;
    logic       to_fire;

    // bit index equals job code
    assign start_vec = {start_agch, start_ns_part2, start_ns_part1,
                        start_part2, start_part1};

    // fixed-priority grant, only offered while idle
    always_comb begin
        grant     = '0;
        grant_job = 3'd0;
        if (state_q == S_IDLE) begin
            if (pend_q[0]) begin
                grant[0]  = 1'b1;
                grant_job = 3'd0;
            end else if (pend_q[2]) begin
                grant[2]  = 1'b1;
                grant_job = 3'd2;
            end else if (pend_q[4]) begin
                grant[4]  = 1'b1;
                grant_job = 3'd4;
            end else if (pend_q[1]) begin
                grant[1]  = 1'b1;
                grant_job = 3'd1;
            end else if (pend_q[3]) begin
                grant[3]  = 1'b1;
                grant_job = 3'd3;
            end
        end
    end

    // a request landing on its own grant is kept as a fresh job, not an overflow;
    // new overflow events take precedence over the clear
    always_comb begin
        pend_d = (pend_q & ~grant) | start_vec;
        ovf_d  = (ovf_q & ~{5{ovf_clr}}) | (start_vec & pend_q & ~grant);
    end

    // pending and sticky overflow registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef VDEC_HS_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] cnt_q;
    logic            tmo_q;

    assign to_fire = ((state_q == S_WAIT_BUSY) || (state_q == S_RUN)) && !dec_done &&
                     (cnt_q >= (TO_MAX - TO_W'(1)));

    // watchdog counter and sticky abort flag; a new abort wins over the clear
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (state_q == S_LAUNCH)
                cnt_q <= '0;
            else if ((state_q == S_WAIT_BUSY) || (state_q == S_RUN))
                cnt_q <= cnt_q + TO_W'(1);
            tmo_q <= (tmo_q & ~ovf_clr) | to_fire;
        end
    end

    assign tmo = tmo_q;
`else
    logic unused_to;

    assign unused_to = ^TO_MAX;
    assign to_fire   = 1'b0;
    assign tmo       = 1'b0;
`endif

    // job sequencing FSM with registered launch and done strobes
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            job_q   <= 3'd0;
            start_q <= 1'b0;
            done_q  <= '0;
        end else begin
            start_q <= 1'b0;
            done_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|pend_q) begin
                        job_q   <= grant_job;
                        start_q <= 1'b1;
                        state_q <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    state_q <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (dec_done || to_fire) begin
                        done_q  <= 5'd1 << job_q;
                        state_q <= S_FIN;
                    end else if (dec_busy) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (dec_done || to_fire) begin
                        done_q  <= 5'd1 << job_q;
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dec_start            = start_q;
    assign dec_job              = job_q;
    assign done_hsscch_part1    = done_q[0];
    assign done_hsscch_part2    = done_q[1];
    assign done_ns_hsscch_part1 = done_q[2];
    assign done_ns_hsscch_part2 = done_q[3];
    assign done_agch            = done_q[4];
    assign pend                 = pend_q;
    assign ovf                  = ovf_q;
    assign sched_busy           = (state_q != S_IDLE) | (|pend_q);

endmodule

// File: tb/tb_vdec_hs_sched.sv
// Testbench for vdec_hs_sched: directed stimulus, scoreboard of expected
// launch/done events checked by an independent monitor.
module tb_vdec_hs_sched;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start_part1 = 1'b0, start_part2 = 1'b0;
    logic       start_ns_part1 = 1'b0, start_ns_part2 = 1'b0, start_agch = 1'b0;
    logic       dec_busy = 1'b0, dec_done = 1'b0, ovf_clr = 1'b0;
    logic       dec_start;
    logic [2:0] dec_job;
    logic       done_hsscch_part1, done_hsscch_part2;
    logic       done_ns_hsscch_part1, done_ns_hsscch_part2, done_agch;
    logic       sched_busy, tmo;
    logic [4:0] pend, ovf;

    vdec_hs_sched #(.TO_W(12), .TO_MAX(12'd20)) dut (
        .clk(clk), .res(res),
        .start_part1(start_part1), .start_part2(start_part2),
        .start_ns_part1(start_ns_part1), .start_ns_part2(start_ns_part2),
        .start_agch(start_agch),
        .dec_busy(dec_busy), .dec_done(dec_done),
        .dec_start(dec_start), .dec_job(dec_job),
        .done_hsscch_part1(done_hsscch_part1), .done_hsscch_part2(done_hsscch_part2),
        .done_ns_hsscch_part1(done_ns_hsscch_part1),
        .done_ns_hsscch_part2(done_ns_hsscch_part2),
        .done_agch(done_agch),
        .sched_busy(sched_busy), .pend(pend), .ovf(ovf),
        .ovf_clr(ovf_clr), .tmo(tmo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int kind;   // 0 launch, 1 done
        int job;
        int cyc;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input int kind, input int job, input int c);
        ev_t e;
        e.kind = kind;
        e.job  = job;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // decoder model: busy from l+1, done pulse at l+len
    task automatic run_dec(input int l, input int len);
        goto(l + 1);
        dec_busy = 1'b1;
        goto(l + len);
        dec_done = 1'b1;
        goto(l + len + 1);
        dec_done = 1'b0;
        dec_busy = 1'b0;
    endtask

    task automatic check_evt(input int kind, input int job);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event @cyc %0d: got kind=%0d job=%0d, expected none",
                     cyc, kind, job);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.job != job || e.cyc != cyc) begin
                n_bad++;
                $display("FAIL event: got kind=%0d job=%0d cyc=%0d, expected kind=%0d job=%0d cyc=%0d",
                         kind, job, cyc, e.kind, e.job, e.cyc);
            end
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT launches or completes
    always @(negedge clk) begin
        logic [4:0] dv;
        int idx;
        dv = {done_agch, done_ns_hsscch_part2, done_ns_hsscch_part1,
              done_hsscch_part2, done_hsscch_part1};
        if (!res) begin
            if (dec_start) check_evt(0, int'(dec_job));
            if (dv != 5'd0) begin
                if ($countones(dv) != 1) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL multi_done @cyc %0d: got %b, expected one-hot", cyc, dv);
                end else begin
                    idx = 0;
                    for (int i = 0; i < 5; i++) if (dv[i]) idx = i;
                    check_evt(1, idx);
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL sim_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        // reset state
        goto(1);
        chk("rst_dec_start", int'(dec_start), 0);
        chk("rst_dec_job", int'(dec_job), 0);
        chk("rst_done", int'({done_agch, done_ns_hsscch_part2, done_ns_hsscch_part1,
                              done_hsscch_part2, done_hsscch_part1}), 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_tmo", int'(tmo), 0);
        chk("rst_sched_busy", int'(sched_busy), 0);
        goto(2);
        res = 1'b0;

        // single request
        push_ev(0, 0, 12);
        push_ev(1, 0, 41);
        goto(10);
        start_part1 = 1'b1;
        goto(11);
        start_part1 = 1'b0;
        chk("single_pend", int'(pend), 5'b00001);
        run_dec(12, 28);
        chk("single_busy_fin", int'(sched_busy), 1);
        goto(42);
        chk("single_idle", int'(sched_busy), 0);

        // simultaneous requests: ns_part1, agch, part2
        push_ev(0, 2, 52); push_ev(1, 2, 58);
        push_ev(0, 4, 60); push_ev(1, 4, 66);
        push_ev(0, 1, 68); push_ev(1, 1, 74);
        goto(50);
        start_part2 = 1'b1; start_agch = 1'b1; start_ns_part1 = 1'b1;
        goto(51);
        start_part2 = 1'b0; start_agch = 1'b0; start_ns_part1 = 1'b0;
        chk("simul_pend", int'(pend), 5'b10110);
        goto(52);
        chk("simul_pend_grant", int'(pend), 5'b10010);
        run_dec(52, 5);
        goto(59);
        chk("simul_busy_pending", int'(sched_busy), 1);
        run_dec(60, 5);
        run_dec(68, 5);
        goto(75);
        chk("simul_idle", int'(sched_busy), 0);

        // merge / overflow
        push_ev(0, 0, 82); push_ev(1, 0, 103);
        push_ev(0, 4, 105); push_ev(1, 4, 110);
        goto(80);
        start_part1 = 1'b1;
        goto(81);
        start_part1 = 1'b0;
        goto(83);
        dec_busy = 1'b1;
        goto(85);
        start_agch = 1'b1;
        goto(86);
        start_agch = 1'b0;
        goto(88);
        start_agch = 1'b1;
        goto(89);
        start_agch = 1'b0;
        chk("merge_ovf", int'(ovf), 5'b10000);
        chk("merge_pend", int'(pend), 5'b10000);
        goto(102);
        dec_done = 1'b1;
        goto(103);
        dec_done = 1'b0;
        dec_busy = 1'b0;
        run_dec(105, 4);
        goto(111);
        chk("merge_ovf_sticky", int'(ovf), 5'b10000);
        goto(112);
        ovf_clr = 1'b1;
        goto(113);
        ovf_clr = 1'b0;
        chk("ovf_clr", int'(ovf), 0);

        // request coincident with its own grant
        push_ev(0, 1, 122); push_ev(1, 1, 127);
        push_ev(0, 1, 129); push_ev(1, 1, 134);
        goto(120);
        start_part2 = 1'b1;
        goto(122);
        start_part2 = 1'b0;
        chk("coinc_pend", int'(pend), 5'b00010);
        chk("coinc_ovf", int'(ovf), 0);
        run_dec(122, 4);
        run_dec(129, 4);
        goto(135);
        chk("coinc_ovf_after", int'(ovf), 0);

        // new overflow wins over same-cycle clear
        push_ev(0, 3, 142); push_ev(1, 3, 153);
        push_ev(0, 3, 155); push_ev(1, 3, 159);
        goto(140);
        start_ns_part2 = 1'b1;
        goto(141);
        start_ns_part2 = 1'b0;
        goto(143);
        dec_busy = 1'b1;
        goto(144);
        start_ns_part2 = 1'b1;
        goto(145);
        start_ns_part2 = 1'b0;
        goto(146);
        start_ns_part2 = 1'b1;
        ovf_clr = 1'b1;
        goto(147);
        start_ns_part2 = 1'b0;
        ovf_clr = 1'b0;
        chk("ovf_vs_clr", int'(ovf), 5'b01000);
        goto(152);
        dec_done = 1'b1;
        goto(153);
        dec_done = 1'b0;
        dec_busy = 1'b0;
        run_dec(155, 3);
        goto(161);
        ovf_clr = 1'b1;
        goto(162);
        ovf_clr = 1'b0;
        chk("ovf_clr2", int'(ovf), 0);

        // early done, busy never seen
        push_ev(0, 4, 172); push_ev(1, 4, 174);
        goto(170);
        start_agch = 1'b1;
        goto(171);
        start_agch = 1'b0;
        goto(173);
        dec_done = 1'b1;
        goto(174);
        dec_done = 1'b0;
        goto(175);
        chk("early_idle", int'(sched_busy), 0);

        // reset mid-job: no done pulse for the aborted job
        push_ev(0, 0, 182);
        goto(180);
        start_part1 = 1'b1;
        goto(181);
        start_part1 = 1'b0;
        goto(183);
        dec_busy = 1'b1;
        goto(190);
        res = 1'b1;
        goto(191);
        chk("midrst_sched_busy", int'(sched_busy), 0);
        chk("midrst_dec_start", int'(dec_start), 0);
        chk("midrst_done", int'({done_agch, done_ns_hsscch_part2, done_ns_hsscch_part1,
                                 done_hsscch_part2, done_hsscch_part1}), 0);
        goto(193);
        res = 1'b0;
        dec_busy = 1'b0;
        goto(195);
        chk("postrst_sched_busy", int'(sched_busy), 0);
        chk("postrst_dec_job", int'(dec_job), 0);
        chk("postrst_pend", int'(pend), 0);

`ifdef VDEC_HS_SCHED_TIMEOUT_EN
        // watchdog abort with TO_MAX = 20
        push_ev(0, 0, 202); push_ev(1, 0, 223);
        goto(200);
        start_part1 = 1'b1;
        goto(201);
        start_part1 = 1'b0;
        goto(203);
        dec_busy = 1'b1;
        goto(224);
        dec_busy = 1'b0;
        chk("tmo_set", int'(tmo), 1);
        goto(226);
        ovf_clr = 1'b1;
        goto(227);
        ovf_clr = 1'b0;
        chk("tmo_clr", int'(tmo), 0);
`else
        goto(224);
        chk("tmo_tied", int'(tmo), 0);
`endif

        goto(250);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vdec_hs_sched.md
Name: vdec_hs_sched

Overview:
- Job scheduler in front of the shared HS Viterbi decoder (vdec_hs).
- Latches single-cycle start requests: HS-SCCH part1/part2, non-serving HS-SCCH part1/part2, E-AGCH.
- Dispatches one job at a time to the decoder by fixed priority.
- Tracks decoder busy/done and returns a per-job done pulse to the requesting channel controller.

Parameters:
- TO_W, 12, width of the decode watchdog counter.
- TO_MAX, 12'd3000, watchdog limit in clk cycles (307.2 MHz); used only with the optional feature.

Ports:
- clk  in  1  decoder clock, 307.2 MHz
- res  in  1  asynchronous reset, active-high
- start_part1  in  1  HS-SCCH part1 request pulse
- start_part2  in  1  HS-SCCH part2 request pulse
- start_ns_part1  in  1  non-serving HS-SCCH part1 request pulse
- start_ns_part2  in  1  non-serving HS-SCCH part2 request pulse
- start_agch  in  1  E-AGCH request pulse
- dec_busy  in  1  decoder busy level
- dec_done  in  1  decoder done pulse
- dec_start  out  1  one-cycle job launch to decoder
- dec_job  out  3  job code of current/last launch: 0 part1, 1 part2, 2 ns_part1, 3 ns_part2, 4 agch
- done_hsscch_part1, done_hsscch_part2, done_ns_hsscch_part1, done_ns_hsscch_part2, done_agch  out  1 each  per-job completion pulse
- sched_busy  out  1  job in flight or any request pending
- pend  out  5  pending request bits, bit index = job code
- ovf  out  5  sticky overflow per job (request arrived while already pending)
- ovf_clr  in  1  clears ovf (and tmo) for one cycle
- tmo  out  1  sticky watchdog abort flag (0 when feature compiled out)

Behaviour:
- Reset: all outputs 0; FSM in IDLE; dec_job = 0; pend, ovf, tmo = 0.
- Request capture: start_x in cycle N sets pend[x] at N+1.
- If pend[x] is already 1 and not granted in N, ovf[x] sets; the request merges (one job only).
- If start_x coincides with the grant of job x, pend[x] stays 1 (new request kept); no overflow.
- Arbitration priority, highest first: part1 > ns_part1 > agch > part2 > ns_part2.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN, FIN.
- IDLE: if pend != 0, select the highest-priority job, clear its pend bit, load dec_job, go to LAUNCH.
- LAUNCH: dec_start = 1 for exactly one cycle; go to WAIT_BUSY.
- WAIT_BUSY: dec_busy = 1 -> RUN. If dec_done arrives before busy is seen, go to FIN directly.
- RUN: on dec_done -> FIN. dec_busy falling without dec_done is ignored.
- FIN: the done_<dec_job> pulse is high for exactly one cycle; go to IDLE.
- Latency:
  - Idle scheduler: start_x at N -> dec_start at N+2.
  - dec_done at M -> done pulse at M+1; next dec_start earliest at M+3.
- Output timing: dec_job is stable from LAUNCH until the next LAUNCH. Exactly one done output is high at a time.
- sched_busy = (state != IDLE) | (pend != 0).
- ovf_clr: same-cycle new overflow events win over the clear.
- Reset mid-job: everything returns to reset values; no done pulse is issued for the aborted job.

Optional Feature:
- Macro: VDEC_HS_SCHED_TIMEOUT_EN.
- When defined:
  - A TO_W-bit counter clears on LAUNCH and increments in WAIT_BUSY and RUN.
  - Reaching TO_MAX without dec_done forces FIN; the done pulse is still emitted so channel controllers never hang.
  - tmo sets sticky; ovf_clr clears it.
- When undefined: no counter; tmo is tied to 0; WAIT_BUSY and RUN wait indefinitely.

Test Plan:
- Single request: start_part1 at cycle 10 -> dec_start at 12, dec_job = 0. dec_busy 13..40, dec_done at 40 -> done_hsscch_part1 at 41 only; sched_busy = 0 at 42.
- Simultaneous requests: start_part2, start_agch and start_ns_part1 in the same cycle -> launch order ns_part1 (2), agch (4), part2 (1); three done pulses on the matching outputs.
- Merge/overflow: start_agch twice while part1 is running -> ovf[4] = 1, one agch job only. ovf_clr -> ovf = 0.
- Coincident request: start_part2 in the same cycle its pend bit is granted -> a second part2 job runs afterwards; ovf[1] stays 0.
- Early done: dec_done pulsed one cycle after dec_start with dec_busy never high -> done pulse emitted, FSM returns to IDLE.
- Timeout (macro defined, TO_MAX = 20): launch, never assert dec_done -> done pulse at launch+~22, tmo = 1. Assert res mid-job -> all outputs 0, no done pulse.
